// File: rtl/addc_mc_pkg.sv
// addc_mc_pkg: shared constants, the sign-magnitude conversion helper and the
// stage-1 payload type for the multi-channel DQ+SEZ sign block.
package addc_mc_pkg;

   localparam int DQ_W_DEF  = 16;
   localparam int SEZ_W_DEF = 15;
   localparam int CH_DEF    = 32;
   localparam int CH_W_DEF  = $clog2(CH_DEF);

   // Widest operand the conversion helper accepts; callers cast the result
   // down to their own width.
   localparam int SM_MAX_W  = 32;

   // Sign-magnitude to two's complement. A negative zero yields zero.
   function automatic logic [SM_MAX_W-1:0] sm_to_tc(input logic                neg,
                                                    input logic [SM_MAX_W-1:0] mag);
      return neg ? SM_MAX_W'(-mag) : mag;
   endfunction

   // Stage-1 payload: the summed sample waiting to be resolved into signs.
   typedef struct packed {
      logic                valid;
      logic [CH_W_DEF-1:0] ch;
      logic [DQ_W_DEF-1:0] dqsez;
   } s1_t;

endpackage

// File: rtl/addc_mc_if.sv
// addc_mc_if: sample input, history clear and result output channels of
// addc_mc. Optional macro ADDC_MC_PKS_EN adds the PKS1/PKS2 result bits.
interface addc_mc_if #(
   parameter int DQ_W  = addc_mc_pkg::DQ_W_DEF,
   parameter int SEZ_W = addc_mc_pkg::SEZ_W_DEF,
   parameter int CH_W  = addc_mc_pkg::CH_W_DEF
);

   logic             in_valid;
   logic             in_ready;
   logic [CH_W-1:0]  in_ch;
   logic [DQ_W-1:0]  DQ;
   logic [SEZ_W-1:0] SEZ;
   logic             clr_valid;
   logic [CH_W-1:0]  clr_ch;
   logic             out_valid;
   logic             out_ready;
   logic [CH_W-1:0]  out_ch;
   logic             PK0;
   logic             PK1;
   logic             PK2;
   logic             SIGPK;
`ifdef ADDC_MC_PKS_EN
   logic             PKS1;
   logic             PKS2;
`endif

   // Producer/consumer side (testbench or upstream logic).
   modport master (
      output in_valid, in_ch, DQ, SEZ, clr_valid, clr_ch, out_ready,
      input  in_ready, out_valid, out_ch, PK0, PK1, PK2, SIGPK
`ifdef ADDC_MC_PKS_EN
      , input PKS1, PKS2
`endif
   );

   // The sign block itself.
   modport slave (
      input  in_valid, in_ch, DQ, SEZ, clr_valid, clr_ch, out_ready,
      output in_ready, out_valid, out_ch, PK0, PK1, PK2, SIGPK
`ifdef ADDC_MC_PKS_EN
      , output PKS1, PKS2
`endif
   );

endinterface

// File: rtl/addc_mc_hist.sv
// addc_mc_hist: per-channel two-deep PK0 history (hist1 = previous sample,
// hist2 = two back). Combinational read of the channel being loaded; a clear
// overrides an update to the same channel on the same edge.
module addc_mc_hist #(
   parameter int CH   = addc_mc_pkg::CH_DEF,
   parameter int CH_W = $clog2(CH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [CH_W-1:0] ch,
   output logic            rd_pk1,
   output logic            rd_pk2,
   input  logic            upd_en,
   input  logic            upd_pk0,
   input  logic            clr_en,
   input  logic [CH_W-1:0] clr_ch
);

   logic [CH-1:0] hist1;
   logic [CH-1:0] hist2;

   assign rd_pk1 = hist1[ch];
   assign rd_pk2 = hist2[ch];

   // Shift the new PK0 into the channel's history, then apply any clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: these are plain flops, not a RAM macro, so a full reset is
         // cheap and guarantees every channel starts with a zero history.
         hist1 <= '0;
         hist2 <= '0;
      end else begin
         if (upd_en) begin
            hist2[ch] <= hist1[ch];
            hist1[ch] <= upd_pk0;
         end
         // NOTE: the clear is written last so that, when it hits the channel
         // just updated, its non-blocking assignment is the one that lands.
         if (clr_en) begin
            hist1[clr_ch] <= 1'b0;
            hist2[clr_ch] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/addc_mc.sv
// addc_mc: multi-channel, two-stage pipelined DQ+SEZ sign block for the
// G.726 adaptive predictor. S1 registers DQSEZ and the channel; S2 registers
// PK0, SIGPK, out_ch and the channel's PK1/PK2 history.
// Optional macro ADDC_MC_PKS_EN adds PKS1 = PK0^PK1 and PKS2 = PK0^PK2.
module addc_mc
   import addc_mc_pkg::*;
#(
   parameter int DQ_W  = DQ_W_DEF,
   parameter int SEZ_W = SEZ_W_DEF,
   parameter int CH    = CH_DEF,
   parameter int CH_W  = $clog2(CH)
) (
   input logic      clk,
   input logic      reset,
   addc_mc_if.slave bus
);

   // The S1 payload type is sized by the package defaults.
   if (DQ_W != DQ_W_DEF || CH_W != CH_W_DEF) begin : g_width_chk
      $error("addc_mc: DQ_W/CH_W must match the s1_t payload widths");
   end
   if (SEZ_W >= DQ_W) begin : g_sez_chk
      $error("addc_mc: SEZ_W must be narrower than DQ_W");
   end

   logic            adv;
   logic [DQ_W-1:0] dqi;
   logic [DQ_W-1:0] sezi;
   logic [DQ_W-1:0] dqsez;
   s1_t             s1;
   logic            pk0_new;
   logic            hist_pk1;
   logic            hist_pk2;

   logic            out_valid_q;
   logic [CH_W-1:0] out_ch_q;
   logic            pk0_q;
   logic            pk1_q;
   logic            pk2_q;
   logic            sigpk_q;
`ifdef ADDC_MC_PKS_EN
   logic            pks1_q;
   logic            pks2_q;
`endif

   // The whole pipeline moves together whenever the output slot can take data.
   assign adv          = !out_valid_q || bus.out_ready;
   assign bus.in_ready = adv;

   assign dqi     = DQ_W'(sm_to_tc(bus.DQ[DQ_W-1], SM_MAX_W'(bus.DQ[DQ_W-2:0])));
   assign sezi    = {{(DQ_W-SEZ_W){bus.SEZ[SEZ_W-1]}}, bus.SEZ};
   assign dqsez   = dqi + sezi;
   assign pk0_new = s1.dqsez[DQ_W-1];

   // S1: capture the wrapped sum and channel of the accepted sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of block ordering.
         s1 <= '0;
      end else if (adv) begin
         s1.valid <= bus.in_valid;
         s1.ch    <= bus.in_ch;
         s1.dqsez <= dqsez;
      end
   end

   addc_mc_hist #(
      .CH   (CH),
      .CH_W (CH_W)
   ) u_hist (
      .clk     (clk),
      .reset   (reset),
      .ch      (s1.ch),
      .rd_pk1  (hist_pk1),
      .rd_pk2  (hist_pk2),
      .upd_en  (adv && s1.valid),
      .upd_pk0 (pk0_new),
      .clr_en  (bus.clr_valid),
      .clr_ch  (bus.clr_ch)
   );

   // S2: resolve sign/zero and latch the history seen before this sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         pk0_q       <= 1'b0;
         pk1_q       <= 1'b0;
         pk2_q       <= 1'b0;
         sigpk_q     <= 1'b0;
`ifdef ADDC_MC_PKS_EN
         pks1_q      <= 1'b0;
         pks2_q      <= 1'b0;
`endif
      end else if (adv) begin
         out_valid_q <= s1.valid;
         if (s1.valid) begin
            out_ch_q <= s1.ch;
            pk0_q    <= pk0_new;
            pk1_q    <= hist_pk1;
            pk2_q    <= hist_pk2;
            sigpk_q  <= (s1.dqsez == '0);
`ifdef ADDC_MC_PKS_EN
            pks1_q   <= pk0_new ^ hist_pk1;
            pks2_q   <= pk0_new ^ hist_pk2;
`endif
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.PK0       = pk0_q;
   assign bus.PK1       = pk1_q;
   assign bus.PK2       = pk2_q;
   assign bus.SIGPK     = sigpk_q;
`ifdef ADDC_MC_PKS_EN
   assign bus.PKS1      = pks1_q;
   assign bus.PKS2      = pks2_q;
`endif

   // Channel indices at or above CH have no history entry.
   a_in_ch: assert property (@(posedge clk) disable iff (reset)
      (bus.in_valid && adv) |-> (32'(bus.in_ch) < CH));
   a_clr_ch: assert property (@(posedge clk) disable iff (reset)
      bus.clr_valid |-> (32'(bus.clr_ch) < CH));

endmodule
